mac_operand_feeder: RTL

//  Upstream stage of the serial MAC: deserialises operand pairs from the pin-level shift interface
//  (A and B bits, MSB first, one bit per rising edge of a shift strobe) into WIDTH-bit words.

---
 rtl/mac_pkg.sv | 17 +
 rtl/op_pair_fifo.sv | 66 ++++++
 rtl/mac_operand_feeder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants and types for the serial MAC datapath.
//   MAC_OP_W  : operand width in bits
//   MAC_ACC_W : accumulator width in bits
//   MAC_PAIRS : operand pairs per accumulation frame
//   op_pair_t : one A/B operand pair as buffered between feeder and controller
package mac_pkg;

  localparam int unsigned MAC_OP_W  = 8;
  localparam int unsigned MAC_ACC_W = 20;
  localparam int unsigned MAC_PAIRS = 10;

  typedef struct packed {
    logic [MAC_OP_W-1:0] a;
    logic [MAC_OP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/op_pair_fifo.sv
// Synchronous FIFO of operand pairs.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset; clears pointers and storage
//   clr_i   : synchronous clear, same effect as rst_i, wins over push/pop
//   push_i  : write data_i; dropped when full unless pop_i frees the slot
//   data_i  : pair to write
//   pop_i   : advance the read pointer; ignored when empty
//   data_o  : pair at the read pointer
//   full_o  : Depth pairs buffered
//   empty_o : no pairs buffered
//   count_o : pairs buffered
module op_pair_fifo
  import mac_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  op_pair_t               data_i,
  input  logic                   pop_i,
  output op_pair_t               data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Extra MSB on each pointer separates full from empty.
  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  op_pair_t       mem_q [Depth];
  logic           do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  // A pop on a full FIFO frees the slot the concurrent push writes into.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Deserialises A/B operand bits (MSB first, one bit per rising strobe edge) into pairs,
// buffers them in a FIFO and presents them to the MAC controller over valid/ready.
//   clock, reset   : clock and synchronous active-high reset
//   start_in       : frame restart; clears everything except the strobe edge history
//   shift_strobe   : pre-synchronised strobe level; each 0->1 transition samples one bit
//   shift_a_in/b_in: serial operand bits
//   op_a_out/b_out : pair at FIFO head, op_valid while non-empty, popped by op_ready
//   fifo_count     : pairs buffered
//   overflow       : sticky, a completed pair was dropped on a full FIFO
//   frame_done     : one-cycle pulse after the PAIRS-th pop of a frame
// WIDTH must equal MAC_OP_W since the FIFO stores op_pair_t.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = MAC_OP_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PAIRS = MAC_PAIRS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_in,
  input  logic                   shift_strobe,
  input  logic                   shift_a_in,
  input  logic                   shift_b_in,
  output logic [WIDTH-1:0]       op_a_out,
  output logic [WIDTH-1:0]       op_b_out,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   frame_done
);

  localparam int unsigned BitW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PairW = $clog2(PAIRS + 1);

  logic             strobe_q;
  logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PairW-1:0] pair_cnt_q, pair_cnt_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;

  logic             bit_event, word_done, push, pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] sh_a_next, sh_b_next;
  op_pair_t         push_pair, head_pair;

  assign bit_event = shift_strobe && !strobe_q;
  assign word_done = bit_event && (bit_cnt_q == BitW'(WIDTH - 1));
  assign sh_a_next = {sh_a_q[WIDTH-2:0], shift_a_in};
  assign sh_b_next = {sh_b_q[WIDTH-2:0], shift_b_in};
  assign push      = word_done && !start_in;
  assign pop       = op_valid && op_ready && !start_in;

  assign push_pair.a = sh_a_next;
  assign push_pair.b = sh_b_next;

  op_pair_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .clr_i   (start_in),
    .push_i  (push),
    .data_i  (push_pair),
    .pop_i   (pop),
    .data_o  (head_pair),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign op_valid   = !fifo_empty;
  assign op_a_out   = head_pair.a;
  assign op_b_out   = head_pair.b;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

  always_comb begin
    sh_a_d       = sh_a_q;
    sh_b_d       = sh_b_q;
    bit_cnt_d    = bit_cnt_q;
    pair_cnt_d   = pair_cnt_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    if (start_in) begin
      sh_a_d     = '0;
      sh_b_d     = '0;
      bit_cnt_d  = '0;
      pair_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (bit_event) begin
        sh_a_d    = sh_a_next;
        sh_b_d    = sh_b_next;
        // Wraps even when the completed pair is dropped.
        bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
      end
      if (push && fifo_full && !pop) overflow_d = 1'b1;
      if (pop) begin
        if (pair_cnt_q == PairW'(PAIRS - 1)) begin
          pair_cnt_d   = '0;
          frame_done_d = 1'b1;
        end else begin
          pair_cnt_d = pair_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_q     <= 1'b0;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      bit_cnt_q    <= '0;
      pair_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      strobe_q     <= shift_strobe;
      sh_a_q       <= sh_a_d;
      sh_b_q       <= sh_b_d;
      bit_cnt_q    <= bit_cnt_d;
      pair_cnt_q   <= pair_cnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
